imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pkg.sv | 68 ++++++
 rtl/imm_skid_buf.sv | 72 +++++++
 rtl/imm_gen_pipe.sv | 83 ++++++++
 tb/tb_imm_gen_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types, opcode constants and the immediate decode function for imm_gen_pipe.
// The decode always produces a 64-bit immediate; narrower datapaths keep the low XLEN bits.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [63:0] imm;
        fmt_e        fmt;
        logic        illegal;
    } decode_t;

    function automatic decode_t imm_decode(input logic [31:0] inst, input int unsigned xlen);
        decode_t     r;
        logic [31:0] imm32;
        logic        s;
        s         = inst[31];
        imm32     = '0;
        r.fmt     = FMT_NONE;
        r.illegal = 1'b0;
        case (inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                r.fmt = FMT_I;
                imm32 = {{20{s}}, inst[31:20]};
            end
            OP_STORE: begin
                r.fmt = FMT_S;
                imm32 = {{20{s}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                r.fmt = FMT_B;
                imm32 = {{19{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                r.fmt = FMT_U;
                imm32 = {inst[31:12], 12'b0};
            end
            OP_JAL: begin
                r.fmt = FMT_J;
                imm32 = {{11{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            // Register-register ops carry no immediate but are perfectly legal.
            OP_REG:  r.illegal = 1'b0;
            default: r.illegal = 1'b1;
        endcase
        r.imm = (xlen == 64) ? {{32{imm32[31]}}, imm32} : {32'b0, imm32};
        return r;
    endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready skid buffer: an output register plus one skid register.
// Ready is registered so upstream never sees a combinational path from downstream ready.
module imm_skid_buf #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         ready_q;
    logic         accept;

    assign accept = i_valid && ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (i_flush) begin
            // Only the valid bits drop; stale data stays in place.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_valid_q && !i_ready) begin
            if (accept) begin
                skid_valid_d = 1'b1;
                skid_data_d  = i_data;
            end
        end else if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = i_data;
        end else begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            ready_q      <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            ready_q      <= !skid_valid_d;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decode on accept, register the result with a
// sideband tag behind a skid buffer, and keep a saturating count of illegal opcodes.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag,
    output logic [CNT_W-1:0] o_illegal_cnt
);

    localparam int PW = XLEN + 3 + 1 + TAG_W;

    decode_t         dec;
    logic [XLEN-1:0] imm_x;
    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   out_payload;
    logic            accept;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign dec = imm_decode(i_inst, XLEN);

    generate
        if (XLEN == 64) begin : g_x64
            assign imm_x = dec.imm;
        end else begin : g_x32
            logic unused_hi;
            assign imm_x     = dec.imm[31:0];
            assign unused_hi = ^dec.imm[63:32];
        end
    endgenerate

    assign in_payload = {imm_x, dec.fmt, dec.illegal, i_tag};

    imm_skid_buf #(.W(PW)) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (in_payload),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (out_payload)
    );

    assign {o_imm, o_fmt, o_illegal, o_tag} = out_payload;

    // A flushed accept is discarded, so it must not be counted either.
    assign accept = i_valid && o_ready && !i_flush;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (32-bit, 64-bit, 2-bit counter) share stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, vin, rdy;
    logic [31:0] inst;
    logic [7:0]  tag;

    logic        a_ready, a_valid, a_ill;
    logic [31:0] a_imm;
    logic [2:0]  a_fmt;
    logic [7:0]  a_tag;
    logic [15:0] a_cnt;

    logic        b_ready, b_valid, b_ill;
    logic [63:0] b_imm;
    logic [2:0]  b_fmt;
    logic [7:0]  b_tag;
    logic [15:0] b_cnt;

    logic        c_ready, c_valid, c_ill;
    logic [31:0] c_imm;
    logic [2:0]  c_fmt;
    logic [7:0]  c_tag;
    logic [1:0]  c_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(16)) u32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vin), .o_ready(a_ready),
        .i_inst(inst), .i_tag(tag), .o_valid(a_valid), .i_ready(rdy), .o_imm(a_imm),
        .o_fmt(a_fmt), .o_illegal(a_ill), .o_tag(a_tag), .o_illegal_cnt(a_cnt));

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(16)) u64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vin), .o_ready(b_ready),
        .i_inst(inst), .i_tag(tag), .o_valid(b_valid), .i_ready(rdy), .o_imm(b_imm),
        .o_fmt(b_fmt), .o_illegal(b_ill), .o_tag(b_tag), .o_illegal_cnt(b_cnt));

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) uc2 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(vin), .o_ready(c_ready),
        .i_inst(inst), .i_tag(tag), .o_valid(c_valid), .i_ready(rdy), .o_imm(c_imm),
        .o_fmt(c_fmt), .o_illegal(c_ill), .o_tag(c_tag), .o_illegal_cnt(c_cnt));

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] in, input logic [7:0] t);
        vin  = v;
        inst = in;
        tag  = t;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy = 1'b1; inst = '0; tag = '0;
        tick(); tick();
        chk("rst_valid", a_valid, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_imm", a_imm, 0);
        chk("rst_fmt", a_fmt, 0);
        chk("rst_ill", a_ill, 0);
        chk("rst_tag", a_tag, 0);
        chk("rst_cnt", a_cnt, 0);
        rst = 1'b0;

        drive(1, 32'h00100113, 8'h05); tick();
        chk("addi_valid", a_valid, 1);
        chk("addi_imm", a_imm, 64'h1);
        chk("addi_fmt", a_fmt, 1);
        chk("addi_tag", a_tag, 8'h05);
        chk("addi_imm64", b_imm, 64'h1);

        drive(1, 32'hFE318FE3, 8'h06); tick();
        chk("beq_imm", a_imm, 64'hFFFFFFFE);
        chk("beq_fmt", a_fmt, 3);
        chk("beq_imm64", b_imm, 64'hFFFFFFFFFFFFFFFE);

        drive(1, 32'h001FF06F, 8'h07); tick();
        chk("jal_imm", a_imm, 64'h000FF800);
        chk("jal_fmt", a_fmt, 5);

        drive(1, 32'h800000B7, 8'h08); tick();
        chk("lui_imm", a_imm, 64'h80000000);
        chk("lui_imm64", b_imm, 64'hFFFFFFFF80000000);
        chk("lui_fmt", b_fmt, 4);

        drive(1, 32'hFE312FA3, 8'h09); tick();
        chk("sw_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("sw_fmt", b_fmt, 2);

        drive(1, 32'h002081B3, 8'h0A); tick();
        chk("add_fmt", a_fmt, 0);
        chk("add_ill", a_ill, 0);
        chk("add_imm", a_imm, 0);
        chk("add_cnt", a_cnt, 0);
        chk("add_valid", a_valid, 1);

        // Three illegal opcodes back to back.
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h0000007F, 8'h10 + 8'(k)); tick();
            chk("ill_flag", a_ill, 1);
            chk("ill_imm", a_imm, 0);
            chk("ill_tag", a_tag, 8'h10 + 8'(k));
        end
        chk("ill_cnt3", a_cnt, 3);
        chk("ill_cnt3_w2", c_cnt, 3);
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'h0000007F, 8'h13 + 8'(k)); tick();
        end
        chk("ill_cnt5", a_cnt, 5);
        chk("ill_sat_w2", c_cnt, 3);

        drive(0, 32'h0, 8'h00); tick();
        chk("drain_valid", a_valid, 0);

        // Backpressure: three offered, two accepted, in-order release.
        rdy = 1'b0;
        drive(1, 32'h00100113, 8'h21); tick();
        chk("bp1_valid", a_valid, 1);
        chk("bp1_tag", a_tag, 8'h21);
        chk("bp1_ready", a_ready, 1);
        drive(1, 32'h800000B7, 8'h22); tick();
        chk("bp2_ready", a_ready, 0);
        chk("bp2_tag", a_tag, 8'h21);
        drive(1, 32'hFE318FE3, 8'h23); tick();
        chk("bp3_ready", a_ready, 0);
        chk("bp3_hold_tag", a_tag, 8'h21);
        chk("bp3_hold_fmt", a_fmt, 1);
        drive(0, 32'h0, 8'h00); rdy = 1'b1; tick();
        chk("rel1_valid", a_valid, 1);
        chk("rel1_tag", a_tag, 8'h22);
        chk("rel1_fmt", a_fmt, 4);
        chk("rel1_ready", a_ready, 1);
        tick();
        chk("rel2_valid", a_valid, 0);

        // Fill both entries, then flush with an instruction offered.
        rdy = 1'b0;
        drive(1, 32'h00100113, 8'h31); tick();
        drive(1, 32'h00100113, 8'h32); tick();
        chk("full_ready", a_ready, 0);
        flush = 1'b1;
        drive(1, 32'h0000007F, 8'h33); tick();
        chk("flush_valid", a_valid, 0);
        chk("flush_ready", a_ready, 1);
        chk("flush_cnt", a_cnt, 5);
        // Flush must beat an accept that happens in the same cycle.
        drive(1, 32'h0000007F, 8'h34); tick();
        chk("flush_acc_valid", a_valid, 0);
        chk("flush_acc_cnt", a_cnt, 5);
        flush = 1'b0;

        // Reset in the middle of traffic.
        drive(1, 32'hFE318FE3, 8'h41); tick();
        chk("pre_rst_valid", a_valid, 1);
        rst = 1'b1; tick();
        chk("mrst_valid", a_valid, 0);
        chk("mrst_ready", a_ready, 1);
        chk("mrst_imm", a_imm, 0);
        chk("mrst_fmt", a_fmt, 0);
        chk("mrst_tag", a_tag, 0);
        chk("mrst_cnt", a_cnt, 0);
        chk("mrst_imm64", b_imm, 0);
        rst = 1'b0; drive(0, 32'h0, 8'h00); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
